// File: rtl/muldiv_pkg.sv
// muldiv_pkg
// Shared definitions for the HI/LO multiply/divide sequencer:
//   - DATA_W : default operand and HI/LO width
//   - CNT_W  : width of the per-operation step counter
//   - OP_*   : operation select encoding (mult, multu, div, divu)
//   - state_t: sequencer FSM states
package muldiv_pkg;

  localparam int DATA_W = 32;
  localparam int CNT_W  = $clog2(DATA_W);

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/muldiv_iter_step.sv
// muldiv_iter_step
// One combinational iteration of the sequencer datapath on magnitudes.
//   i_is_div  : 1 = restoring-divide step, 0 = shift-add multiply step
//   i_acc     : partial product high half / partial remainder
//   i_q       : multiplier (shifted out LSB first) / dividend-quotient
//   i_operand : multiplicand / divisor
//   o_acc,o_q : register values for the next cycle
// Multiply: {acc,q} = ({acc + (q[0] ? operand : 0), q}) >> 1.
// Divide:   shift {acc,q} left one, subtract divisor from the top half,
//           keep the difference and shift in 1 if it did not go negative.
module muldiv_iter_step #(
  parameter int DATA_W = 32
) (
  input  logic              i_is_div,
  input  logic [DATA_W-1:0] i_acc,
  input  logic [DATA_W-1:0] i_q,
  input  logic [DATA_W-1:0] i_operand,
  output logic [DATA_W-1:0] o_acc,
  output logic [DATA_W-1:0] o_q
);

  logic [DATA_W:0] w_sum;
  logic [DATA_W:0] w_shift;
  logic [DATA_W:0] w_diff;

  always_comb begin
    w_sum   = {1'b0, i_acc} + {1'b0, i_operand};
    w_shift = {i_acc, i_q[DATA_W-1]};
    // Partial remainder is always below the divisor, so the shifted value
    // fits DATA_W+1 bits and bit DATA_W of the difference is a clean sign.
    w_diff  = w_shift - {1'b0, i_operand};
    if (i_is_div) begin
      if (!w_diff[DATA_W]) begin
        o_acc = w_diff[DATA_W-1:0];
        o_q   = {i_q[DATA_W-2:0], 1'b1};
      end else begin
        o_acc = w_shift[DATA_W-1:0];
        o_q   = {i_q[DATA_W-2:0], 1'b0};
      end
    end else if (i_q[0]) begin
      o_acc = w_sum[DATA_W:1];
      o_q   = {w_sum[0], i_q[DATA_W-1:1]};
    end else begin
      o_acc = {1'b0, i_acc[DATA_W-1:1]};
      o_q   = {i_acc[0], i_q[DATA_W-1:1]};
    end
  end

endmodule

// File: rtl/hilo_muldiv_sequencer.sv
// hilo_muldiv_sequencer
// Iterative MIPS-style multiply/divide unit owning the HI and LO registers.
// An operation takes DATA_W RUN cycles plus one FIX cycle; HI/LO are written
// on the FIX->DONE edge and Done pulses for one cycle afterwards.
// Build option: MULDIV_DIV_EN enables div/divu. Without it a divide request
// goes straight to DONE with HI/LO untouched and DivByZero held low.
// Ports:
//   i_clk, i_rst        : clock, asynchronous active-high reset
//   i_start, i_op       : request and op select (00 mult,01 multu,10 div,11 divu)
//   i_a, i_b            : rs / rt operands, captured when the request is taken
//   i_hilo_read         : datapath is issuing mfhi/mflo this cycle
//   o_busy, o_stall     : operation in flight; pipeline freeze request
//   o_done, o_div_by_zero: commit pulse; divide-by-zero pulse (with Done)
//   o_hi, o_lo          : architectural HI / LO
//   o_state             : FSM state for debug observation
// Handshake: a request is taken on a rising edge where i_start is high and
// the unit is in IDLE or DONE; requests in RUN/FIX are dropped and the
// pipeline sees o_stall for as long as it keeps presenting them.
module hilo_muldiv_sequencer #(
  parameter int DATA_W = muldiv_pkg::DATA_W
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [1:0]        i_op,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  input  logic              i_hilo_read,
  output logic              o_busy,
  output logic              o_stall,
  output logic              o_done,
  output logic              o_div_by_zero,
  output logic [DATA_W-1:0] o_hi,
  output logic [DATA_W-1:0] o_lo,
  output logic [1:0]        o_state
);

  import muldiv_pkg::*;

  localparam int              CW       = $clog2(DATA_W);
  localparam logic [CW-1:0]   CNT_LAST = CW'(DATA_W - 1);

  state_t              r_state;
  logic [CW-1:0]       r_cnt;
  logic [DATA_W-1:0]   r_acc;
  logic [DATA_W-1:0]   r_q;
  logic [DATA_W-1:0]   r_operand;
  logic [DATA_W-1:0]   r_hi;
  logic [DATA_W-1:0]   r_lo;
  logic                r_neg_res;
  logic                r_dbz;
`ifdef MULDIV_DIV_EN
  logic                r_is_div;
  logic                r_neg_rem;
  logic                r_b_zero;
`endif

  logic                w_signed;
  logic [DATA_W-1:0]   w_a_mag;
  logic [DATA_W-1:0]   w_b_mag;
  logic                w_is_div;
  logic [DATA_W-1:0]   w_acc_nxt;
  logic [DATA_W-1:0]   w_q_nxt;
  logic [2*DATA_W-1:0] w_prod;
  logic [DATA_W-1:0]   w_hi_fix;
  logic [DATA_W-1:0]   w_lo_fix;

  assign w_signed = (i_op == OP_MULT) || (i_op == OP_DIV);
  assign w_a_mag  = (w_signed && i_a[DATA_W-1]) ? -i_a : i_a;
  assign w_b_mag  = (w_signed && i_b[DATA_W-1]) ? -i_b : i_b;

`ifdef MULDIV_DIV_EN
  assign w_is_div = r_is_div;
`else
  assign w_is_div = 1'b0;
`endif

  muldiv_iter_step #(.DATA_W(DATA_W)) u_step (
    .i_is_div  (w_is_div),
    .i_acc     (r_acc),
    .i_q       (r_q),
    .i_operand (r_operand),
    .o_acc     (w_acc_nxt),
    .o_q       (w_q_nxt)
  );

  // Sign correction applied in FIX. A zero divisor leaves the magnitude
  // dividend in r_acc, so the remainder path already yields HI = A.
  always_comb begin
    w_prod = {r_acc, r_q};
    if (r_neg_res) w_prod = -w_prod;
    w_hi_fix = w_prod[2*DATA_W-1:DATA_W];
    w_lo_fix = w_prod[DATA_W-1:0];
`ifdef MULDIV_DIV_EN
    if (r_is_div) begin
      w_hi_fix = r_neg_rem ? -r_acc : r_acc;
      w_lo_fix = r_b_zero ? '1 : (r_neg_res ? -r_q : r_q);
    end
`endif
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_acc     <= '0;
      r_q       <= '0;
      r_operand <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_neg_res <= 1'b0;
      r_dbz     <= 1'b0;
`ifdef MULDIV_DIV_EN
      r_is_div  <= 1'b0;
      r_neg_rem <= 1'b0;
      r_b_zero  <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          r_dbz <= 1'b0;
          if (i_start) begin
            r_cnt     <= '0;
            r_acc     <= '0;
            r_neg_res <= w_signed && (i_a[DATA_W-1] ^ i_b[DATA_W-1]);
`ifdef MULDIV_DIV_EN
            r_is_div  <= i_op[1];
            r_neg_rem <= w_signed && i_a[DATA_W-1];
            r_b_zero  <= (i_b == '0);
            r_state   <= ST_RUN;
`else
            r_state   <= i_op[1] ? ST_DONE : ST_RUN;
`endif
            // Divide iterates on the dividend; multiply shifts out the multiplier.
            r_q       <= i_op[1] ? w_a_mag : w_b_mag;
            r_operand <= i_op[1] ? w_b_mag : w_a_mag;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          r_acc <= w_acc_nxt;
          r_q   <= w_q_nxt;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CNT_LAST) r_state <= ST_FIX;
        end
        ST_FIX: begin
          r_hi    <= w_hi_fix;
          r_lo    <= w_lo_fix;
`ifdef MULDIV_DIV_EN
          r_dbz   <= r_is_div && r_b_zero;
`else
          r_dbz   <= 1'b0;
`endif
          r_state <= ST_DONE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_busy        = (r_state == ST_RUN) || (r_state == ST_FIX);
  assign o_stall       = o_busy && (i_start || i_hilo_read);
  assign o_done        = (r_state == ST_DONE);
  assign o_div_by_zero = r_dbz;
  assign o_hi          = r_hi;
  assign o_lo          = r_lo;
  assign o_state       = r_state;

endmodule

// File: tb/tb_hilo_muldiv_sequencer.sv
// tb_hilo_muldiv_sequencer
// Random and directed operations checked against an arithmetic reference
// model of HI/LO; latency, Busy/Stall behaviour, hold of HI/LO and reset.
module tb_hilo_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        i_rst;
  logic        i_start;
  logic [1:0]  i_op;
  logic [31:0] i_a;
  logic [31:0] i_b;
  logic        i_hilo_read;
  logic        o_busy;
  logic        o_stall;
  logic        o_done;
  logic        o_div_by_zero;
  logic [31:0] o_hi;
  logic [31:0] o_lo;
  logic [1:0]  o_state;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;
  logic [64:0] exp_q[$];

  hilo_muldiv_sequencer #(.DATA_W(32)) dut (
    .i_clk         (clk),
    .i_rst         (i_rst),
    .i_start       (i_start),
    .i_op          (i_op),
    .i_a           (i_a),
    .i_b           (i_b),
    .i_hilo_read   (i_hilo_read),
    .o_busy        (o_busy),
    .o_stall       (o_stall),
    .o_done        (o_done),
    .o_div_by_zero (o_div_by_zero),
    .o_hi          (o_hi),
    .o_lo          (o_lo),
    .o_state       (o_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- reference model: returns {dbz, hi, lo} ----------------
  function automatic logic [64:0] model(input logic [1:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    longint      sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      2'b00: begin p = sa * sb;                   return {1'b0, p}; end
      2'b01: begin p = {32'b0, a} * {32'b0, b};   return {1'b0, p}; end
`ifdef MULDIV_DIV_EN
      2'b10: begin
        if (b == 0) return {1'b1, a, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        return {1'b0, r[31:0], q[31:0]};
      end
      default: begin
        if (b == 0) return {1'b1, a, 32'hFFFF_FFFF};
        return {1'b0, a % b, a / b};
      end
`else
      default: return {1'b0, m_hi, m_lo};
`endif
    endcase
  endfunction

  // ---------------- driver: issue one op and follow it to Done ----------------
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int inject_at);
    logic [64:0] e;
    int lat_exp, n, busy_err, stall_err, hold_err;
    bit seen;
    bit bypass;
`ifdef MULDIV_DIV_EN
    bypass = 1'b0;
`else
    bypass = op[1];
`endif
    lat_exp = bypass ? 1 : 34;
    exp_q.push_back(model(op, a, b));
    busy_err = 0; stall_err = 0; hold_err = 0; seen = 0;
    i_start = 1'b1; i_op = op; i_a = a; i_b = b;
    i_hilo_read = 1'($urandom_range(0, 1));
    #1 check("stall_when_idle", {63'b0, o_stall}, 64'd0);
    for (n = 1; n <= 40; n++) begin
      @(negedge clk);
      i_start = 1'b0;
      i_hilo_read = 1'($urandom_range(0, 1));
      if (n == inject_at) begin
        i_start = 1'b1; i_hilo_read = 1'b1;
        i_op = ~op; i_a = $urandom; i_b = $urandom;
      end
      #1;
      if (o_done) begin seen = 1; break; end
      if (n == inject_at) check("stall_on_inject", {63'b0, o_stall}, 64'd1);
      if (!o_busy) busy_err++;
      if (o_stall !== (i_start | i_hilo_read)) stall_err++;
      if (o_hi !== m_hi || o_lo !== m_lo) hold_err++;
    end
    e = exp_q.pop_front();
    check("done_seen", {63'b0, seen}, 64'd1);
    check("latency", 64'(n), 64'(lat_exp));
    check("busy_while_running", 64'(busy_err), 64'd0);
    check("stall_while_running", 64'(stall_err), 64'd0);
    check("hilo_hold", 64'(hold_err), 64'd0);
    check("busy_in_done", {63'b0, o_busy}, 64'd0);
    check("hi", {32'b0, o_hi}, {32'b0, e[63:32]});
    check("lo", {32'b0, o_lo}, {32'b0, e[31:0]});
    check("div_by_zero", {63'b0, o_div_by_zero}, {63'b0, e[64]});
    m_hi = e[63:32];
    m_lo = e[31:0];
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      4: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    int done_err;
    i_rst = 1'b1; i_start = 1'b1; i_op = 2'b01; i_a = 32'h5; i_b = 32'h7; i_hilo_read = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("rst_busy", {63'b0, o_busy}, 64'd0);
    check("rst_stall", {63'b0, o_stall}, 64'd0);
    check("rst_done", {63'b0, o_done}, 64'd0);
    check("rst_dbz", {63'b0, o_div_by_zero}, 64'd0);
    check("rst_hi", {32'b0, o_hi}, 64'd0);
    check("rst_lo", {32'b0, o_lo}, 64'd0);
    @(negedge clk);
    i_start = 1'b0; i_hilo_read = 1'b0; i_rst = 1'b0;
    repeat (3) @(negedge clk);
    #1 check("start_during_reset_ignored", {63'b0, o_busy}, 64'd0);

    // directed cases
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    check("multu_max_hi", {32'b0, o_hi}, 64'hFFFF_FFFE);
    check("multu_max_lo", {32'b0, o_lo}, 64'h0000_0001);
    run_op(2'b00, 32'hFFFF_FFFD, 32'd7, 0);
    check("mult_neg_hi", {32'b0, o_hi}, 64'hFFFF_FFFF);
    check("mult_neg_lo", {32'b0, o_lo}, 64'hFFFF_FFEB);
`ifdef MULDIV_DIV_EN
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 0);
    check("div_neg_lo", {32'b0, o_lo}, 64'hFFFF_FFFD);
    check("div_neg_hi", {32'b0, o_hi}, 64'hFFFF_FFFF);
    run_op(2'b11, 32'h64, 32'd0, 0);
    check("divu_zero_dbz", {62'b0, o_div_by_zero, o_done}, 64'd3);
    check("divu_zero_hi", {32'b0, o_hi}, 64'h0000_0064);
    check("divu_zero_lo", {32'b0, o_lo}, 64'hFFFF_FFFF);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    check("div_wrap_lo", {32'b0, o_lo}, 64'h8000_0000);
    check("div_wrap_hi", {32'b0, o_hi}, 64'd0);
    run_op(2'b10, 32'hFFFF_FFF9, 32'd0, 0);
`else
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 0);
    check("div_bypass_hi", {32'b0, o_hi}, 64'hFFFF_FFFF);
    check("div_bypass_lo", {32'b0, o_lo}, 64'hFFFF_FFEB);
    run_op(2'b11, 32'h64, 32'd0, 0);
`endif

    // Start + HiLoRead in cycle 5 of a running mult
    run_op(2'b00, 32'h1234_5678, 32'hFEDC_BA98, 5);

    // randomized traffic, with occasional idle gaps between ops
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      #1;
      run_op(2'($urandom_range(0, 3)), pick_operand(), pick_operand(),
             ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 30)) : 0);
    end

    // reset in cycle 10 of an operation; Start held during reset
    run_op(2'b01, 32'hDEAD_BEEF, 32'h1357_9BDF, 0);
`ifdef MULDIV_DIV_EN
    i_op = 2'b10;
`else
    i_op = 2'b00;
`endif
    i_start = 1'b1; i_a = 32'hFFFF_FFF9; i_b = 32'd3;
    @(negedge clk);
    i_start = 1'b0;
    repeat (9) @(negedge clk);
    i_rst = 1'b1; i_start = 1'b1;
    #1;
    check("midrst_busy", {63'b0, o_busy}, 64'd0);
    check("midrst_hi", {32'b0, o_hi}, 64'd0);
    check("midrst_lo", {32'b0, o_lo}, 64'd0);
    check("midrst_done", {63'b0, o_done}, 64'd0);
    @(negedge clk);
    i_rst = 1'b0; i_start = 1'b0;
    m_hi = '0; m_lo = '0;
    done_err = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      #1;
      if (o_done || o_busy) done_err++;
    end
    check("midrst_no_done", 64'(done_err), 64'd0);

    // unit is usable again after the reset
    run_op(2'b00, 32'h8000_0000, 32'h8000_0000, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
